// File: rtl/led_rate_decoder_if.sv
// led_rate_decoder_if: LED input, enable and decoded-rate outputs of the rate decoder.
interface led_rate_decoder_if #(parameter int c_width = 32);
  logic i_enable;
  logic i_led;
  logic o_select0;
  logic o_select1;
  logic o_valid;
  logic o_error;
  logic [c_width-1:0] o_half_period;
  modport master(output i_enable, i_led, input o_select0, o_select1, o_valid, o_error, o_half_period);
  modport slave(input i_enable, i_led, output o_select0, o_select1, o_valid, o_error, o_half_period);
endinterface

// File: rtl/led_rate_decoder.sv
// led_rate_decoder: recovers the blinker select code from the measured LED half-period.
module led_rate_decoder #(
  parameter int c_max_count_1Hz = 25000000,
  parameter int c_max_count_5Hz = 5000000,
  parameter int c_max_count_10Hz = 2500000,
  parameter int c_max_count_20Hz = 1250000,
  parameter int c_tol = 2,
  parameter int c_width = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  led_rate_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEASURE, CONFIRM, LOCKED} state_t;
  localparam longint c_timeout = longint'(c_max_count_1Hz) + c_tol + 1;
  state_t state_q;
  logic s1_q, s2_q, s3_q, e_q;
  logic [c_width-1:0] cnt_q, cnt_d, n, half_q;
  logic [1:0] cand_q, sel_q, code;
  logic valid_q, err_q, any, to;
  function automatic logic hit(input logic [c_width-1:0] v, input int nom);
    return longint'(v) + c_tol >= longint'(nom) && longint'(v) <= longint'(nom) + c_tol;
  endfunction
  // n is the edge-to-edge distance the current cycle would close if e is high
  always_comb begin
    n = &cnt_q ? cnt_q : cnt_q + 1'b1;
    cnt_d = e_q ? '0 : n;
    code = hit(n, c_max_count_20Hz) ? 2'd3 : hit(n, c_max_count_10Hz) ? 2'd2 :
           hit(n, c_max_count_5Hz) ? 2'd1 : 2'd0;
    any = hit(n, c_max_count_20Hz) | hit(n, c_max_count_10Hz) | hit(n, c_max_count_5Hz) | hit(n, c_max_count_1Hz);
    to = longint'(n) >= c_timeout;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      {s1_q, s2_q, s3_q, e_q} <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= bus.i_led;
      s2_q <= s1_q;
      s3_q <= s2_q;
      e_q <= s2_q ^ s3_q;
      cnt_q <= bus.i_enable ? cnt_d : '0;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      {cand_q, sel_q, valid_q, err_q} <= '0;
      half_q <= '0;
    end else if (!bus.i_enable) begin
      state_q <= IDLE;
      {cand_q, sel_q, valid_q, err_q} <= '0;
      half_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (e_q && state_q != IDLE) half_q <= n;
      case (state_q)
        IDLE: if (e_q) state_q <= MEASURE;
        MEASURE: if (e_q) begin
          if (any) begin
            cand_q <= code;
            state_q <= CONFIRM;
          end else err_q <= 1'b1;
        end
        CONFIRM: if (e_q) begin
          if (!any) begin
            err_q <= 1'b1;
            state_q <= MEASURE;
          end else if (code == cand_q) begin
            sel_q <= code;
            valid_q <= 1'b1;
            state_q <= LOCKED;
          end else cand_q <= code;
        end
        LOCKED: if (e_q) begin
          if (!any) begin
            valid_q <= 1'b0;
            err_q <= 1'b1;
            state_q <= MEASURE;
          end else if (code != cand_q) begin
            valid_q <= 1'b0;
            cand_q <= code;
            state_q <= CONFIRM;
          end
        end
        default: state_q <= IDLE;
      endcase
      // a line that stops toggling drops lock and restarts acquisition
      if (!e_q && to && state_q != IDLE) begin
        valid_q <= 1'b0;
        err_q <= 1'b1;
        state_q <= IDLE;
      end
    end
  assign bus.o_select0 = sel_q[0];
  assign bus.o_select1 = sel_q[1];
  assign bus.o_valid = valid_q;
  assign bus.o_error = err_q;
  assign bus.o_half_period = half_q;
endmodule

// File: tb/tb_led_rate_decoder.sv
// tb_led_rate_decoder: directed checks of lock, boundaries, rate change, timeout, reset and enable.
module tb_led_rate_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int base;
  led_rate_decoder_if #(.c_width(8)) bus();
  led_rate_decoder #(
    .c_max_count_1Hz(25), .c_max_count_5Hz(10), .c_max_count_10Hz(5),
    .c_max_count_20Hz(2), .c_tol(1), .c_width(8)
  ) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.o_error) pulses++;
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic tog();
    bus.i_led = ~bus.i_led;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 0);
    chk({tag, "_error"}, 32'(bus.o_error), 0);
    chk({tag, "_sel"}, 32'({bus.o_select1, bus.o_select0}), 0);
    chk({tag, "_half"}, 32'(bus.o_half_period), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_led = 1'b0;
    tick(3);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick(1);
    base = pulses;
    tog(); tick(5); tog(); tick(5); tog(); tick(3);
    chk("steady_prelock", 32'(bus.o_valid), 0);
    tick(1);
    chk("steady_valid", 32'(bus.o_valid), 1);
    chk("steady_sel", 32'({bus.o_select1, bus.o_select0}), 2);
    chk("steady_half", 32'(bus.o_half_period), 5);
    tick(1);
    tog(); tick(5); tog(); tick(5);
    chk("steady_hold", 32'(bus.o_valid), 1);
    chk("steady_noerr", 32'(pulses - base), 0);
    tog(); tick(2);
    #3 rst_n = 1'b0;
    #1 chk_idle_outputs("async_reset");
    bus.i_led = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    tog(); tick(5); tog(); tick(5);
    chk("relock_two_edges", 32'(bus.o_valid), 0);
    tog(); tick(4);
    chk("relock_valid", 32'(bus.o_valid), 1);
    tick(1);
    base = pulses;
    tick(19); tog(); tick(26); tog(); tick(4);
    chk("bound_valid", 32'(bus.o_valid), 1);
    chk("bound_sel", 32'({bus.o_select1, bus.o_select0}), 0);
    chk("bound_half", 32'(bus.o_half_period), 26);
    tick(23); tog(); tick(3);
    chk("bound27_before", 32'(bus.o_error), 0);
    tick(1);
    chk("bound27_error", 32'(bus.o_error), 1);
    chk("bound27_valid", 32'(bus.o_valid), 0);
    chk("bound27_half", 32'(bus.o_half_period), 27);
    tick(1);
    chk("bound27_pulse_end", 32'(bus.o_error), 0);
    chk("bound_err_count", 32'(pulses - base), 1);
    base = pulses;
    repeat (5) begin
      tog(); tick(2);
    end
    chk("fast_valid", 32'(bus.o_valid), 1);
    chk("fast_sel", 32'({bus.o_select1, bus.o_select0}), 3);
    chk("fast_half", 32'(bus.o_half_period), 2);
    tick(8); tog(); tick(4);
    chk("change_drop", 32'(bus.o_valid), 0);
    tick(6); tog(); tick(4);
    chk("change_valid", 32'(bus.o_valid), 1);
    chk("change_sel", 32'({bus.o_select1, bus.o_select0}), 1);
    chk("change_half", 32'(bus.o_half_period), 10);
    chk("change_noerr", 32'(pulses - base), 0);
    base = pulses;
    tick(26);
    chk("stuck_before_valid", 32'(bus.o_valid), 1);
    chk("stuck_before_err", 32'(bus.o_error), 0);
    tick(1);
    chk("stuck_error", 32'(bus.o_error), 1);
    chk("stuck_valid", 32'(bus.o_valid), 0);
    tick(1);
    chk("stuck_pulse_end", 32'(bus.o_error), 0);
    chk("stuck_err_count", 32'(pulses - base), 1);
    tog(); tick(5);
    chk("stuck_single_edge", 32'(bus.o_valid), 0);
    tog(); tick(5); tog(); tick(5);
    chk("pre_dis_valid", 32'(bus.o_valid), 1);
    chk("pre_dis_sel", 32'({bus.o_select1, bus.o_select0}), 2);
    base = pulses;
    bus.i_enable = 1'b0;
    tick(1);
    chk_idle_outputs("disable");
    tick(4);
    repeat (3) begin
      tog(); tick(5);
    end
    chk("dis_valid", 32'(bus.o_valid), 0);
    chk("dis_noerr", 32'(pulses - base), 0);
    bus.i_enable = 1'b1;
    tick(5);
    tog(); tick(5); tog(); tick(5);
    chk("reen_two_edges", 32'(bus.o_valid), 0);
    tog(); tick(4);
    chk("reen_valid", 32'(bus.o_valid), 1);
    chk("reen_sel", 32'({bus.o_select1, bus.o_select0}), 2);
    chk("reen_noerr", 32'(pulses - base), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_rate_decoder.md
Name: led_rate_decoder

Overview:
- Receive-side counterpart of the LED blinker: samples a blinking LED line and recovers which blink rate, and therefore which {select1,select0} code, is driving it.
- Measures the clock-cycle distance between successive LED edges and classifies each half-period against the four blinker max-count parameters.
- Reports a locked rate code with valid and error flags.
- Used in loop-back self-test: blinker output feeds this block, and the decoded code is compared with the applied select inputs.

Parameters:
- c_max_count_1Hz, 25000000, nominal half-period in clocks for code 00
- c_max_count_5Hz, 5000000, nominal half-period in clocks for code 01
- c_max_count_10Hz, 2500000, nominal half-period in clocks for code 10
- c_max_count_20Hz, 1250000, nominal half-period in clocks for code 11
- c_tol, 2, accepted deviation (+/- clocks) around each nominal value
- c_width, 32, width of the half-period counter and o_half_period

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_enable  input  1  decoder enable; low forces IDLE and clears all outputs
- i_led  input  1  LED line under test, asynchronous to i_clk
- o_select0  output  1  decoded code bit 0
- o_select1  output  1  decoded code bit 1
- o_valid  output  1  high while locked on a rate
- o_error  output  1  one-cycle pulse on unmatched half-period or timeout
- o_half_period  output  c_width  last measured half-period in clocks

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - all outputs 0, synchronizer flops 0, counter 0, state IDLE.
  - Reset asserted mid-lock takes effect immediately, with no further output activity.
- Input path: i_led passes a 2-FF synchronizer, then a registered edge detect (rise or fall) producing one-cycle pulse e. Pin to e latency is 3 clocks.
- Measurement:
  - counter cleared on every e cycle, otherwise increments, saturating at all-ones.
  - N = number of clocks between two consecutive e pulses. At the second pulse, N is captured into o_half_period in the next cycle.
- Classification: N matches a code when |N - c_max_count_X| <= c_tol. If windows overlap, the smallest nominal count wins (priority 11, 10, 01, 00).
- States:
  - IDLE: wait for first e, then go to MEASURE. No classification is made on the first edge.
  - MEASURE: on e, classify N.
    - Match: store as candidate code, go to CONFIRM.
    - No match: pulse o_error, stay in MEASURE.
  - CONFIRM: on e, classify N.
    - Same code as candidate: load o_select1/o_select0, set o_valid, go to LOCKED.
    - Different match: becomes the new candidate, stay in CONFIRM.
    - No match: pulse o_error, go to MEASURE.
  - LOCKED: on e, classify N.
    - Same code: hold.
    - Different match: clear o_valid, new candidate, go to CONFIRM.
    - No match: clear o_valid, pulse o_error, go to MEASURE.
- Timeout: in MEASURE, CONFIRM or LOCKED, when the counter reaches c_max_count_1Hz + c_tol + 1 with no e:
  - clear o_valid, pulse o_error, go to IDLE.
  - This covers a blinker that is disabled (line held low) or stuck.
- Output update timing: o_valid, o_select* and o_error change on the clock after the e pulse (or after the timeout compare). o_select* hold their last value while o_valid=0, except that they are cleared by reset or by i_enable=0.
- i_enable=0: synchronous clear of the counter, state (to IDLE) and all outputs; the synchronizer keeps running. Edges seen in the first cycle after re-enable start from IDLE.
- o_error never asserts in IDLE.

Test Plan (params 25/10/5/2, c_tol=1, c_width=8):
- Reset: assert i_rst_n=0 mid-run with toggling LED -> all outputs 0 within the same cycle, without waiting for a clock edge; release -> IDLE, o_valid=0 until two matching half-periods are seen.
- Steady 10Hz: toggle i_led every 5 clocks -> o_valid=1 one clock after the 3rd detected edge, {o_select1,o_select0}=10, o_half_period=5, o_error never pulses.
- Boundary: half-periods of 24 and 26 -> lock on code 00; half-period 27 -> o_error one-cycle pulse, o_valid=0.
- Rate change: lock on 2-clock toggling (code 11), then switch to 10-clock toggling -> o_valid drops at the first 10-clock half-period with no o_error, re-asserts with code 01 after the second.
- Stuck line: after lock, hold i_led constant -> 27 clocks after the last e, o_valid=0, o_error pulses once, state IDLE (next single edge does not lock).
- Enable: drive i_enable=0 while locked -> all outputs 0 next clock and no o_error while disabled; re-enable with 5-clock toggling -> relocks to code 10.
